jk_excite_ctrl: RTL and testbench



---
 rtl/jk_excite_ctrl.sv | 140 ++++++++++++++
 tb/tb_jk_excite_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_ctrl.sv
// Sequencing controller for an external JK flip-flop bank: derives J/K excitation for
// hold/up/down/load sequences and verifies flop feedback. Optional build macro: JK_TOGGLE_PREF_EN.
module jk_excite_ctrl #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [STEP_W-1:0] steps,
    input  logic [WIDTH-1:0]  q_fb,
    output logic [WIDTH-1:0]  j,
    output logic [WIDTH-1:0]  k,
    output logic [WIDTH-1:0]  expect_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [1:0]         mode_r, mode_n;
    logic [WIDTH-1:0]   lv_r, lv_n;
    logic [STEP_W-1:0]  cnt, cnt_n;
    logic [WIDTH-1:0]   j_n, k_n, exp_n, tgt;
    logic               err_n;

    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] c,
                                                  input logic [1:0] m,
                                                  input logic [WIDTH-1:0] lv);
        case (m)
            2'b00:   return c;
            2'b01:   return c + WIDTH'(1);
            2'b10:   return c - WIDTH'(1);
            default: return lv;
        endcase
    endfunction

    // Don't-care excitation resolution: toggle preference or minimal J/K activity.
    function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] c,
                                               input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_PREF_EN
        return c ^ t;
`else
        return t & ~c;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] c,
                                               input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_PREF_EN
        return c ^ t;
`else
        return c & ~t;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_r   <= 2'b00;
            lv_r     <= '0;
            cnt      <= '0;
            j        <= '0;
            k        <= '0;
            expect_q <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            mode_r   <= mode_n;
            lv_r     <= lv_n;
            cnt      <= cnt_n;
            j        <= j_n;
            k        <= k_n;
            expect_q <= exp_n;
            err      <= err_n;
        end
    end

    // J/K default to zero so the bank holds in every cycle except DRIVE.
    always_comb begin
        state_n = state;
        mode_n  = mode_r;
        lv_n    = lv_r;
        cnt_n   = cnt;
        j_n     = '0;
        k_n     = '0;
        exp_n   = expect_q;
        err_n   = err;
        tgt     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_n = mode;
                    lv_n   = load_val;
                    cnt_n  = steps;
                    err_n  = 1'b0;
                    if (steps == '0) begin
                        state_n = DONE;
                    end else begin
                        tgt     = next_val(q_fb, mode, load_val);
                        j_n     = exc_j(q_fb, tgt);
                        k_n     = exc_k(q_fb, tgt);
                        exp_n   = tgt;
                        state_n = DRIVE;
                    end
                end
            end
            DRIVE: state_n = CHECK;
            CHECK: begin
                if (q_fb != expect_q) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else if (cnt > STEP_W'(1)) begin
                    cnt_n   = cnt - STEP_W'(1);
                    tgt     = next_val(expect_q, mode_r, lv_r);
                    j_n     = exc_j(expect_q, tgt);
                    k_n     = exc_k(expect_q, tgt);
                    exp_n   = tgt;
                    state_n = DRIVE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Self-checking bench for jk_excite_ctrl: drives a behavioural JK bank and compares
// each DRIVE cycle against a scoreboard of expected J/K/target values.
module tb_jk_excite_ctrl;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] mode;
    logic [3:0] load_val, q_fb, j, k, expect_q;
    logic [7:0] steps;
    logic       busy, done, err;

    logic [3:0] mq;
    logic [3:0] stuck;
    logic       pre_en;
    logic [3:0] pre_val;

    int checks = 0;
    int errors = 0;
    logic [11:0] sb[$];

    jk_excite_ctrl #(.WIDTH(4), .STEP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .load_val(load_val),
        .steps(steps), .q_fb(q_fb), .j(j), .k(k), .expect_q(expect_q),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank with preload and optional stuck-at-0 feedback bits.
    always @(posedge clk) begin
        if (pre_en) mq <= pre_val;
        else begin
            for (int b = 0; b < 4; b++) begin
                case ({j[b], k[b]})
                    2'b01:   mq[b] <= 1'b0;
                    2'b10:   mq[b] <= 1'b1;
                    2'b11:   mq[b] <= ~mq[b];
                    default: mq[b] <= mq[b];
                endcase
            end
        end
    end
    assign q_fb = mq & ~stuck;

    function automatic logic [3:0] model_next(input logic [3:0] c, input logic [1:0] m,
                                              input logic [3:0] lv);
        logic [3:0] r;
        case (m)
            2'b00: r = c;
            2'b01: r = (c == 4'hF) ? 4'h0 : c + 4'h1;
            2'b10: r = (c == 4'h0) ? 4'hF : c - 4'h1;
            default: r = lv;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] model_exc(input logic [3:0] c, input logic [3:0] t);
        logic [3:0] jj, kk;
        for (int b = 0; b < 4; b++) begin
            case ({c[b], t[b]})
                2'b01: begin
                    jj[b] = 1'b1;
`ifdef JK_TOGGLE_PREF_EN
                    kk[b] = 1'b1;
`else
                    kk[b] = 1'b0;
`endif
                end
                2'b10: begin
`ifdef JK_TOGGLE_PREF_EN
                    jj[b] = 1'b1;
`else
                    jj[b] = 1'b0;
`endif
                    kk[b] = 1'b1;
                end
                default: begin
                    jj[b] = 1'b0;
                    kk[b] = 1'b0;
                end
            endcase
        end
        return {jj, kk};
    endfunction

    task automatic preload(input logic [3:0] v);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_val = v;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // Runs one operation; ndrive = number of DRIVE cycles expected before completion.
    task automatic applyStimulus(input string name, input logic [1:0] m, input logic [3:0] lv,
                                 input logic [7:0] n, input int ndrive, input bit exp_err,
                                 input bit poke);
        logic [3:0] cur, tgt, fin;
        logic [7:0] ex;
        logic [11:0] e;
        int last;
        cur = q_fb;
        for (int i = 0; i < ndrive; i++) begin
            tgt = model_next(cur, m, lv);
            ex  = model_exc(cur, tgt);
            sb.push_back({ex, tgt});
            cur = tgt;
        end
        fin  = cur;
        last = 2 * ndrive + 1;
        @(negedge clk);
        mode = m; load_val = lv; steps = n; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && c == 2) begin
                start = 1'b1; mode = ~m; steps = 8'd0; load_val = ~lv;
            end
            if (c == 1) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++; $display("[TB] FAIL %s err_clear: got %b want 0", name, err);
                end
            end
            if (c <= last) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("[TB] FAIL %s busy c%0d: got %b want 1", name, c, busy);
                end
                checks++;
                if (done !== (c == last)) begin
                    errors++;
                    $display("[TB] FAIL %s done c%0d: got %b want %b", name, c, done, c == last);
                end
            end
            if (c < last && (c % 2) == 1) begin
                if (sb.size() == 0) begin
                    errors++; $display("[TB] FAIL %s scoreboard_empty c%0d", name, c);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if ({j, k, expect_q} !== e) begin
                        errors++;
                        $display("[TB] FAIL %s drive c%0d: got j=%b k=%b exp=%b want j=%b k=%b exp=%b",
                                 name, c, j, k, expect_q, e[11:8], e[7:4], e[3:0]);
                    end
                end
            end else begin
                checks++;
                if ({j, k} !== 8'h00) begin
                    errors++;
                    $display("[TB] FAIL %s jk_idle c%0d: got j=%b k=%b want 0000/0000", name, c, j, k);
                end
            end
            if (c == last) begin
                checks++;
                if (err !== exp_err) begin
                    errors++; $display("[TB] FAIL %s err_final: got %b want %b", name, err, exp_err);
                end
                if (!exp_err) begin
                    checks++;
                    if (q_fb !== fin) begin
                        errors++; $display("[TB] FAIL %s final_q: got %b want %b", name, q_fb, fin);
                    end
                end
            end
            if (c == last + 1) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s post_idle: got busy=%b done=%b want 0/0", name, busy, done);
                end
            end
        end
        sb.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({j, k, expect_q, busy, done, err} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset: got j=%b k=%b exp=%b busy=%b done=%b err=%b want all 0",
                     j, k, expect_q, busy, done, err);
        end
        rst = 1'b0;
    endtask

    task automatic test_count;
        preload(4'h0);
        applyStimulus("up3", 2'b01, 4'h0, 8'd3, 3, 1'b0, 1'b0);
        preload(4'hF);
        applyStimulus("up_wrap", 2'b01, 4'h0, 8'd1, 1, 1'b0, 1'b0);
        preload(4'h0);
        applyStimulus("down2", 2'b10, 4'h0, 8'd2, 2, 1'b0, 1'b0);
        preload(4'h6);
        applyStimulus("hold2", 2'b00, 4'h0, 8'd2, 2, 1'b0, 1'b0);
    endtask

    task automatic test_load;
        preload(4'h5);
        applyStimulus("load2", 2'b11, 4'hA, 8'd2, 2, 1'b0, 1'b0);
    endtask

    task automatic test_mismatch;
        preload(4'h0);
        stuck = 4'b0001;
        applyStimulus("stuck", 2'b01, 4'h0, 8'd4, 1, 1'b1, 1'b0);
        checkOutput();
        stuck = 4'b0000;
        preload(4'h3);
        applyStimulus("after_err", 2'b00, 4'h0, 8'd1, 1, 1'b0, 1'b0);
    endtask

    task automatic checkOutput;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("[TB] FAIL err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_back_to_back;
        preload(4'h2);
        applyStimulus("steps0", 2'b01, 4'h0, 8'd0, 0, 1'b0, 1'b0);
        preload(4'h2);
        applyStimulus("busy_start", 2'b01, 4'h0, 8'd2, 2, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        preload(4'h0);
        @(negedge clk);
        mode = 2'b01; steps = 8'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({j, k, expect_q, busy, done} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got j=%b k=%b exp=%b busy=%b done=%b want all 0",
                     j, k, expect_q, busy, done);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mode = 2'b00; load_val = 4'h0; steps = 8'd0;
        stuck = 4'b0000; pre_en = 1'b1; pre_val = 4'h0;
        test_reset();
        test_count();
        test_load();
        test_mismatch();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
